// File: rtl/counter_5bit.sv
// rtl/counter_5bit.sv - free-running modulo up-counter with Gray output, wrap pulse and sticky overflow
module counter_5bit #(
  parameter int unsigned     WIDTH       = 5,
  parameter longint unsigned MODULUS     = 64'd1 << WIDTH,
  parameter longint unsigned STEP        = 1,
  parameter longint unsigned RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             wrap,
  output logic             overflow
);

  // Parameter legality; any violation stops elaboration.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "counter_5bit: WIDTH=%0d outside 1..32", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "counter_5bit: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
  end
  if (STEP == 0 || STEP >= MODULUS) begin : g_bad_step
    $fatal(1, "counter_5bit: STEP=%0d outside 1..MODULUS-1", STEP);
  end
  if (RESET_VALUE >= MODULUS) begin : g_bad_reset_value
    $fatal(1, "counter_5bit: RESET_VALUE=%0d not below MODULUS", RESET_VALUE);
  end

  // One extra bit so count + STEP and the modulus compare never overflow.
  localparam logic [WIDTH:0]   MOD_W   = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0]   STEP_W  = STEP[WIDTH:0];
  localparam logic [WIDTH-1:0] RESET_W = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_G = RESET_W ^ (RESET_W >> 1);

  logic [WIDTH:0]   sum;
  logic             is_wrap;
  logic [WIDTH-1:0] next_count;

  // Next count: add STEP, fold back by MODULUS when the sum reaches it.
  always_comb begin
    sum        = {1'b0, count} + STEP_W;
    is_wrap    = (sum >= MOD_W);
    next_count = is_wrap ? WIDTH'(sum - MOD_W) : WIDTH'(sum);
  end

  // Registered outputs; Gray is derived from next_count so it matches count every cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count      <= RESET_W;
      count_gray <= RESET_G;
      wrap       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      count      <= next_count;
      count_gray <= next_count ^ (next_count >> 1);
      wrap       <= is_wrap;
      overflow   <= overflow | is_wrap;
    end
  end

endmodule

// File: tb/tb_counter_5bit.sv
// tb/tb_counter_5bit.sv - randomized reset stimulus against an arithmetic model for four counter configurations
module tb_counter_5bit;

  localparam int ND = 4;
  // Configurations: defaults, mod-10 step-3, reset value 7, odd 6-bit case.
  localparam longint PM[ND]  = '{32, 10, 32, 45};
  localparam longint PS[ND]  = '{1, 3, 1, 17};
  localparam longint PRV[ND] = '{0, 0, 7, 44};

  logic       clock;
  logic [3:0] rst;
  logic [4:0] c0, g0;
  logic [3:0] c1, g1;
  logic [4:0] c2, g2;
  logic [5:0] c3, g3;
  logic [3:0] w, ov;

  counter_5bit u_def (.clock(clock), .reset(rst[0]), .count(c0), .count_gray(g0), .wrap(w[0]), .overflow(ov[0]));
  counter_5bit #(.WIDTH(4), .MODULUS(10), .STEP(3), .RESET_VALUE(0))
    u_m10 (.clock(clock), .reset(rst[1]), .count(c1), .count_gray(g1), .wrap(w[1]), .overflow(ov[1]));
  counter_5bit #(.RESET_VALUE(7))
    u_rv7 (.clock(clock), .reset(rst[2]), .count(c2), .count_gray(g2), .wrap(w[2]), .overflow(ov[2]));
  counter_5bit #(.WIDTH(6), .MODULUS(45), .STEP(17), .RESET_VALUE(44))
    u_odd (.clock(clock), .reset(rst[3]), .count(c3), .count_gray(g3), .wrap(w[3]), .overflow(ov[3]));

  int total = 0;
  int bad   = 0;

  // Edges counted since the last reset edge; -1 means no reset seen yet.
  longint n[ND] = '{-1, -1, -1, -1};
  logic [4:0] prev_g0 = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint get_c(input int d);
    case (d)
      0: return longint'(c0);
      1: return longint'(c1);
      2: return longint'(c2);
      default: return longint'(c3);
    endcase
  endfunction

  function automatic longint get_g(input int d);
    case (d)
      0: return longint'(g0);
      1: return longint'(g1);
      2: return longint'(g2);
      default: return longint'(g3);
    endcase
  endfunction

  // Model: after k counting edges the unreduced position is RV + k*STEP;
  // count is that mod M, and the number of wraps so far is that div M.
  function automatic longint pos(input int d, input longint k);
    return PRV[d] + k * PS[d];
  endfunction
  function automatic longint m_count(input int d, input longint k);
    return pos(d, k) % PM[d];
  endfunction
  function automatic longint m_wrap(input int d, input longint k);
    if (k == 0) return 0;
    return (pos(d, k) / PM[d]) != (pos(d, k - 1) / PM[d]) ? 1 : 0;
  endfunction
  function automatic longint m_ovf(input int d, input longint k);
    return (pos(d, k) / PM[d]) != 0 ? 1 : 0;
  endfunction

  // Model advance on each rising edge, using the reset level the DUTs sample.
  always @(posedge clock) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst[d]) n[d] = 0;
      else if (n[d] >= 0) n[d] = n[d] + 1;
    end
  end

  // Per-cycle compare of every DUT against the model, away from the active edge.
  always @(negedge clock) begin
    for (int d = 0; d < ND; d++) begin
      if (n[d] >= 0) begin
        longint c;
        c = m_count(d, n[d]);
        chk($sformatf("count[%0d]", d), get_c(d), c);
        chk($sformatf("gray[%0d]", d), get_g(d), c ^ (c >> 1));
        chk($sformatf("wrap[%0d]", d), longint'(w[d]), m_wrap(d, n[d]));
        chk($sformatf("overflow[%0d]", d), longint'(ov[d]), m_ovf(d, n[d]));
        chk($sformatf("range[%0d]", d), (get_c(d) < PM[d]) ? 1 : 0, 1);
      end
    end
    if (n[0] >= 1)
      chk("gray_step1", longint'($countones(g0 ^ prev_g0)), 1);
    prev_g0 = g0;
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  longint seq10[11] = '{0, 3, 6, 9, 2, 5, 8, 1, 4, 7, 0};

  initial begin
    rst = 4'b0000;
    // Reset held for 20 edges: everything pinned at reset values.
    repeat (20) begin
      cyc();
      chk("hold_c0", longint'(c0), 0);
      chk("hold_g0", longint'(g0), 0);
      chk("hold_w0", longint'(w[0]), 0);
      chk("hold_c2", longint'(c2), 7);
    end
    chk("seq10_0", longint'(c1), seq10[0]);
    chk("pin_model_m10", m_count(1, 7), 1);
    chk("pin_model_odd", m_count(3, 1), 16);
    rst = 4'b1111;

    for (int i = 1; i <= 50; i++) begin
      cyc();
      if (i <= 10) begin
        chk("seq10", longint'(c1), seq10[i]);
        chk("seq10_wrap", longint'(w[1]), (i == 4 || i == 7 || i == 10) ? 1 : 0);
      end
      if (i == 1)  chk("first_inc", longint'(c0), 1);
      if (i == 31) begin
        chk("c0_at31", longint'(c0), 31);
        chk("w0_at31", longint'(w[0]), 0);
        chk("ov0_at31", longint'(ov[0]), 0);
      end
      if (i == 32) begin
        chk("c0_wrap", longint'(c0), 0);
        chk("w0_wrap", longint'(w[0]), 1);
        chk("ov0_wrap", longint'(ov[0]), 1);
        chk("gray_31_0", longint'(g0), 0);
      end
      if (i == 33) begin
        chk("w0_after", longint'(w[0]), 0);
        chk("ov0_sticky", longint'(ov[0]), 1);
      end
      if (i == 45) begin
        chk("c2_at20", longint'(c2), 20);
        chk("ov2_set", longint'(ov[2]), 1);
        rst[2] = 1'b0;
      end
      if (i == 46) begin
        chk("c2_reset", longint'(c2), 7);
        chk("ov2_clear", longint'(ov[2]), 0);
        rst[2] = 1'b1;
      end
      if (i == 47) chk("c2_resume", longint'(c2), 8);
    end

    // Reset asserted exactly on the edge that would wrap 31 -> 0.
    rst[0] = 1'b0;
    cyc();
    rst[0] = 1'b1;
    repeat (31) cyc();
    chk("c0_pre", longint'(c0), 31);
    rst[0] = 1'b0;
    cyc();
    chk("rstwrap_c", longint'(c0), 0);
    chk("rstwrap_w", longint'(w[0]), 0);
    chk("rstwrap_ov", longint'(ov[0]), 0);
    rst[0] = 1'b1;

    // Randomized reset pulses against the model.
    repeat (3000) begin
      cyc();
      for (int d = 0; d < ND; d++)
        rst[d] = ($urandom_range(0, 39) != 0);
    end
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
